// File: rtl/add_sub_module_pkg.sv
// Shared sizing and state encoding for the matrix add/subtract block and its siblings.
package add_sub_module_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned DIM    = 4;
  localparam int unsigned BUS_W  = DIM * DIM * ELEM_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } as_state_e;

endpackage

// File: rtl/add_sub_module_as_lane.sv
// One element lane: wrap-around add or subtract of a single operand pair.
module as_lane #(
  parameter int unsigned ELEM_W = 16
) (
  input  logic [ELEM_W-1:0] i_a,
  input  logic [ELEM_W-1:0] i_b,
  input  logic              i_add,
  output logic [ELEM_W-1:0] o_res
);

  always_comb begin
    o_res = i_add ? (i_a + i_b) : (i_a - i_b);
  end

endmodule

// File: rtl/add_sub_module.sv
// Matrix add/subtract engine: capture A and B over the shared bus, then compute A op B per element.
module add_sub_module
  import add_sub_module_pkg::*;
#(
  parameter int unsigned ELEM_W = add_sub_module_pkg::ELEM_W,
  parameter int unsigned DIM    = add_sub_module_pkg::DIM
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic [DIM*DIM*ELEM_W-1:0] toModuleBus,
  input  logic                      addRW,
  input  logic                      addEN,
  input  logic                      matDecide,
  input  logic                      add1sub0,
  output logic [DIM*DIM*ELEM_W-1:0] fromASBus,
  output logic                      addFleg
);

  localparam int unsigned Lanes = DIM * DIM;
  localparam int unsigned BusW  = Lanes * ELEM_W;

  as_state_e        r_state;
  as_state_e        w_state_next;
  logic [BusW-1:0]  r_a;
  logic [BusW-1:0]  r_b;
  logic [BusW-1:0]  r_result;
  logic             r_op;
  logic [BusW-1:0]  w_lane_res;
  logic             w_wr_en;
  logic             w_req;

  // Operand writes are honoured from both IDLE and DONE; COMPUTE ignores the bus.
  assign w_wr_en = addEN && !addRW && (r_state != COMPUTE);
  assign w_req   = addEN && addRW && (r_state == IDLE);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req) w_state_next = COMPUTE;
      end
      COMPUTE: w_state_next = DONE;
      DONE: begin
        if (!addEN || !addRW) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    addFleg   = (r_state == DONE);
    fromASBus = r_result;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_op     <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (matDecide) r_b <= toModuleBus;
        else           r_a <= toModuleBus;
      end
      if (w_req) r_op <= add1sub0;
      if (r_state == COMPUTE) r_result <= w_lane_res;
    end
  end

  for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
    as_lane #(
      .ELEM_W (ELEM_W)
    ) u_lane (
      .i_a   (r_a[gi*ELEM_W +: ELEM_W]),
      .i_b   (r_b[gi*ELEM_W +: ELEM_W]),
      .i_add (r_op),
      .o_res (w_lane_res[gi*ELEM_W +: ELEM_W])
    );
  end

endmodule

// File: tb/tb_add_sub_module.sv
// Randomized and directed bench for add_sub_module against an element-wise arithmetic model.
module tb_add_sub_module;

  logic         clk = 1'b0;
  logic         RESET;
  logic [255:0] toModuleBus;
  logic         addRW, addEN, matDecide, add1sub0;
  logic [255:0] fromASBus;
  logic         addFleg;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Model: operand matrices, last result, op, and a phase (0 idle, 1 computing, 2 done).
  logic [255:0] m_a, m_b, m_res;
  logic         m_op;
  int           m_phase;

  add_sub_module dut (
    .clk         (clk),
    .RESET       (RESET),
    .toModuleBus (toModuleBus),
    .addRW       (addRW),
    .addEN       (addEN),
    .matDecide   (matDecide),
    .add1sub0    (add1sub0),
    .fromASBus   (fromASBus),
    .addFleg     (addFleg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] calc(input logic [255:0] a, input logic [255:0] b,
                                        input logic add);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) begin
      int sa, sb, s;
      logic [31:0] sv;
      sa = int'($signed(a[i*16 +: 16]));
      sb = int'($signed(b[i*16 +: 16]));
      s  = add ? sa + sb : sa - sb;
      sv = s;
      r[i*16 +: 16] = sv[15:0];
    end
    return r;
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [255:0] rand_bus();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_a = '0; m_b = '0; m_res = '0; m_op = 1'b0; m_phase = 0;
  endtask

  task automatic capture(input logic md, input logic [255:0] bus);
    if (md) m_b = bus;
    else    m_a = bus;
  endtask

  // Apply one cycle of inputs, let the DUT sample them, then advance the model.
  task automatic step(input logic en, input logic rw, input logic md, input logic op,
                      input logic [255:0] bus);
    #1;
    addEN = en; addRW = rw; matDecide = md; add1sub0 = op; toModuleBus = bus;
    @(posedge clk);
    case (m_phase)
      0: if (en) begin
        if (!rw) capture(md, bus);
        else begin m_op = op; m_phase = 1; end
      end
      1: begin m_res = calc(m_a, m_b, m_op); m_phase = 2; end
      default: begin
        if (!en) m_phase = 0;
        else if (!rw) begin capture(md, bus); m_phase = 0; end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("bus", fromASBus, m_res);
      chk("flag", {255'd0, addFleg}, {255'd0, (m_phase == 2)});
    end
  end

  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic op);
    step(1, 0, 0, 0, a);
    step(1, 0, 1, 0, b);
    step(1, 1, 0, op, rand_bus());
    step(1, 1, 0, ~op, rand_bus());
  endtask

  initial begin
    logic [255:0] v;
    RESET = 1'b1; addEN = 0; addRW = 0; matDecide = 0; add1sub0 = 0; toModuleBus = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bus", fromASBus, 256'd0);
    chk("reset_flag", {255'd0, addFleg}, 256'd0);
    @(negedge clk);
    RESET = 1'b0;
    cmp_on = 1'b1;

    // All ones plus all twos.
    run_op(fill(16'd1), fill(16'd2), 1'b1);
    @(negedge clk);
    chk("lit_add3", fromASBus, fill(16'd3));
    chk("lit_add3_flag", {255'd0, addFleg}, 256'd1);
    step(0, 0, 0, 0, rand_bus());

    // Ramp minus one, element 0 wraps to 0xFFFF.
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(i);
    run_op(v, fill(16'd1), 1'b0);
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(i - 1);
    @(negedge clk);
    chk("lit_ramp_sub", fromASBus, v);
    chk("lit_elem0", {240'd0, fromASBus[15:0]}, {240'd0, 16'hFFFF});
    step(0, 0, 0, 0, rand_bus());

    run_op(fill(16'h7FFF), fill(16'd1), 1'b1);
    @(negedge clk);
    chk("lit_wrap_add", fromASBus, fill(16'h8000));
    step(0, 0, 0, 0, rand_bus());
    run_op(fill(16'h8000), fill(16'd1), 1'b0);
    @(negedge clk);
    chk("lit_wrap_sub", fromASBus, fill(16'h7FFF));

    // Drop enable in DONE, then rewrite B and recompute.
    step(0, 1, 1, 1, rand_bus());
    step(1, 0, 1, 0, fill(16'd5));
    step(1, 1, 0, 1, rand_bus());
    step(1, 1, 0, 1, rand_bus());
    step(1, 1, 0, 1, rand_bus());
    @(negedge clk);
    chk("lit_newb", fromASBus, fill(16'h8005));

    // Disabled for 10 cycles with inputs toggling.
    step(0, 0, 0, 0, rand_bus());
    for (int i = 0; i < 10; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), rand_bus());
    step(1, 1, 0, 1, rand_bus());
    step(1, 1, 0, 1, rand_bus());
    step(0, 0, 0, 0, rand_bus());

    // Reset mid-COMPUTE clears outputs immediately and the operands.
    step(1, 0, 0, 0, fill(16'd9));
    step(1, 1, 0, 1, rand_bus());
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_compute_bus", fromASBus, 256'd0);
    chk("rst_compute_flag", {255'd0, addFleg}, 256'd0);
    model_reset();
    @(negedge clk);
    RESET = 1'b0;
    step(1, 1, 0, 1, rand_bus());
    step(1, 1, 0, 1, rand_bus());
    @(negedge clk);
    chk("post_rst_zero", fromASBus, 256'd0);
    chk("post_rst_flag", {255'd0, addFleg}, 256'd1);
    step(0, 0, 0, 0, rand_bus());

    // Random traffic, biased toward enabled cycles.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           rand_bus());
    @(negedge clk);
    cmp_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sub_module.md
ADD_SUB_MODULE -- requirements
Module: AddSubModule

Interface
REQ-001 Parameter ELEM_W, default 16, width of one signed matrix element.
REQ-002 Parameter DIM, default 4, matrix is DIM x DIM; bus width = DIM*DIM*ELEM_W (256).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 toModuleBus  input  256  shared operand bus from engine; element i (row-major, i=4*row+col) at bits [16i+15:16i].
REQ-006 addRW  input  1  0 = write operand, 1 = request result.
REQ-007 addEN  input  1  module enable, active-high; inputs ignored when low.
REQ-008 matDecide  input  1  operand select on write: 0 = matrix A, 1 = matrix B.
REQ-009 add1sub0  input  1  operation: 1 = A+B, 0 = A-B.
REQ-010 fromASBus  output  256  result matrix, same packing as toModuleBus.
REQ-011 addFleg  output  1  result-valid flag, active-high.

Function
REQ-012 States: IDLE, COMPUTE, DONE.
REQ-013 IDLE, addEN=1, addRW=0: capture toModuleBus into A (matDecide=0) or B (matDecide=1); remain IDLE.
REQ-014 IDLE, addEN=1, addRW=1: latch add1sub0 into op register; go to COMPUTE.
REQ-015 COMPUTE: on next edge register result = A op B element-wise, go to DONE unconditionally (inputs ignored).
REQ-016 Latency: request sampled at edge k -> fromASBus updated and addFleg=1 after edge k+1.
REQ-017 DONE: addFleg=1; fromASBus holds result; stay while addEN=1 and addRW=1.
REQ-018 DONE, addEN=0: go to IDLE, addFleg=0 after that edge; fromASBus keeps last result.
REQ-019 DONE, addEN=1, addRW=0: perform operand capture per REQ-013 and go to IDLE (flag clears).
REQ-020 Arithmetic: each element 16-bit two's complement, result truncated to 16 bits (wrap-around, no saturation, no overflow flag); no carry between lanes.
REQ-021 Result computed from A/B as stored; unwritten operands read as zero (reset value); no validity checking.
REQ-022 addFleg is a registered state decode (high only in DONE); fromASBus driven from result register, never combinationally from bus.
REQ-023 Toggling add1sub0 or matDecide outside a sampled write/request has no effect.

Reset
REQ-024 RESET=1 asynchronously forces state=IDLE, A=B=result=0, op=0, addFleg=0, fromASBus=0.
REQ-025 Reset asserted during COMPUTE or DONE aborts operation; no result produced after release.
REQ-026 After RESET deasserts, first rising edge obeys REQ-013/014 normally.

Structure
REQ-027 Shared package holds ELEM_W, DIM, BUS_W=256, and the state enum (IDLE, COMPUTE, DONE) for reuse by the engine and sibling matrix modules.
REQ-028 One sub-module, as_lane: 16-bit combinational add/subtract of one element pair, instantiated DIM*DIM times via generate.

Verification
REQ-029 Write A=all elements 1, B=all 2, request with add1sub0=1 -> after 2 edges addFleg=1, every element 3.
REQ-030 A elements 0..15 (element i=i), B all 1, add1sub0=0 -> element i = i-1; element 0 = 0xFFFF.
REQ-031 A all 0x7FFF, B all 1, add -> all 0x8000 (wrap); A all 0x8000, B all 1, sub -> all 0x7FFF.
REQ-032 In DONE drop addEN -> addFleg=0 next edge, fromASBus unchanged; write new B -> new request gives updated result.
REQ-033 Assert RESET while in COMPUTE -> addFleg and fromASBus 0 immediately (before next edge), state IDLE, A/B cleared.
REQ-034 addEN=0 with bus/RW/matDecide toggling for 10 cycles -> A, B, result, addFleg unchanged.
